// File: rtl/fsm16_pkg.sv
// Shared definitions for steering the 16-state input-pair FSM: state codes,
// the golden successor functions, drive-pair encoding and the next-hop table.
package fsm16_pkg;

    localparam logic [3:0] S0  = 4'd0;
    localparam logic [3:0] S1  = 4'd1;
    localparam logic [3:0] S2  = 4'd2;
    localparam logic [3:0] S3  = 4'd3;
    localparam logic [3:0] S4  = 4'd4;
    localparam logic [3:0] S5  = 4'd5;
    localparam logic [3:0] S6  = 4'd6;
    localparam logic [3:0] S7  = 4'd7;
    localparam logic [3:0] S8  = 4'd8;
    localparam logic [3:0] S9  = 4'd9;
    localparam logic [3:0] S10 = 4'd10;
    localparam logic [3:0] S11 = 4'd11;
    localparam logic [3:0] S12 = 4'd12;
    localparam logic [3:0] S13 = 4'd13;
    localparam logic [3:0] S14 = 4'd14;
    localparam logic [3:0] S15 = 4'd15;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TIMEOUT  = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;

    // Distance value meaning "target not reachable"
    localparam logic [4:0] DIST_INF = 5'd31;

    typedef enum logic {
        CTL_IDLE,
        CTL_RUN
    } ctl_t;

    // Successor taken when the row condition is false: (2j+2) mod 16
    function automatic logic [3:0] succ0(input logic [3:0] s);
        return {s[2:0], 1'b0} + 4'd2;
    endfunction

    // Successor taken when the row condition is true: 2j+1
    function automatic logic [3:0] succ1(input logic [3:0] s);
        return {s[2:0], 1'b1};
    endfunction

    // Canonical (input1,input2) pair that moves cur towards want.
    // Any want other than succ1(cur) gets the "condition false" pair.
    function automatic logic [1:0] enc(input logic [3:0] cur, input logic [3:0] want);
        logic take1;
        logic [1:0] pair;
        take1 = (want == succ1(cur));
        case (cur[2:0])
            3'd0:    pair = take1 ? 2'b11 : 2'b00;
            3'd1:    pair = take1 ? 2'b01 : 2'b00;
            3'd2:    pair = take1 ? 2'b10 : 2'b00;
            3'd3:    pair = take1 ? 2'b00 : 2'b11;
            3'd4:    pair = take1 ? 2'b11 : 2'b00;
            3'd5:    pair = take1 ? 2'b00 : 2'b10;
            3'd6:    pair = take1 ? 2'b00 : 2'b01;
            default: pair = take1 ? 2'b00 : 2'b11;
        endcase
        return pair;
    endfunction

    // Next-hop table, entry (cur*16+tgt) at bits [4*idx +: 4].
    // For each target, relax distance-to-target over all states, then pick
    // the successor with the smaller distance; ties take the lower number and
    // an unreachable target falls back to succ0.
    function automatic logic [1023:0] build_hop_table();
        logic [1023:0] tbl;
        logic [79:0]   d;
        logic [4:0]    a;
        logic [4:0]    b;
        logic [4:0]    m;
        logic [3:0]    n0;
        logic [3:0]    n1;
        logic [3:0]    hop;
        tbl = '0;
        for (int t = 0; t < 16; t++) begin
            d = {16{DIST_INF}};
            d[t*5 +: 5] = 5'd0;
            for (int it = 0; it < 16; it++) begin
                for (int s = 0; s < 16; s++) begin
                    n0 = succ0(4'(s));
                    n1 = succ1(4'(s));
                    a  = d[n0*5 +: 5];
                    b  = d[n1*5 +: 5];
                    m  = (a < b) ? a : b;
                    if (m != DIST_INF && (m + 5'd1) < d[s*5 +: 5]) begin
                        d[s*5 +: 5] = m + 5'd1;
                    end
                end
            end
            for (int c = 0; c < 16; c++) begin
                n0 = succ0(4'(c));
                n1 = succ1(4'(c));
                a  = d[n0*5 +: 5];
                b  = d[n1*5 +: 5];
                if (a == DIST_INF && b == DIST_INF) begin
                    hop = n0;
                end else if (a < b) begin
                    hop = n0;
                end else if (b < a) begin
                    hop = n1;
                end else begin
                    hop = (n0 < n1) ? n0 : n1;
                end
                tbl[(c*16 + t)*4 +: 4] = hop;
            end
        end
        return tbl;
    endfunction

endpackage

// File: rtl/fsm16_route_rom.sv
// Pure lookup: successor of cur on a shortest path to tgt. Table is built at
// elaboration, so this reduces to constant logic.
module fsm16_route_rom
    import fsm16_pkg::*;
(
    input  logic [3:0] cur,
    input  logic [3:0] tgt,
    output logic [3:0] hop
);

    localparam logic [1023:0] HOP_TABLE = build_hop_table();

    logic [3:0] rom [256];

    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        assign rom[gi] = HOP_TABLE[gi*4 +: 4];
    end

    assign hop = rom[{cur, tgt}];

endmodule

// File: rtl/fsm16_steer.sv
// Walks the external fsm_16 to a requested state by the shortest path,
// checking each cycle that the FSM landed where it was predicted to.
module fsm16_steer
    import fsm16_pkg::*;
#(
    parameter int MAX_STEPS = 8,
    parameter int STEP_W    = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_target,
    input  logic [3:0]        fsm_state,
    output logic              input1,
    output logic              input2,
    output logic              done,
    output logic [1:0]        status,
    output logic [STEP_W-1:0] steps_taken
);

    ctl_t              ctl_reg, ctl_next;
    logic [3:0]        tgt_reg, tgt_next;
    logic [3:0]        exp_reg, exp_next;
    logic              chk_en_reg, chk_en_next;
    logic [STEP_W-1:0] steps_reg, steps_next;
    logic              done_reg, done_next;
    logic [1:0]        status_reg, status_next;
    logic [STEP_W-1:0] steps_out_reg, steps_out_next;

    logic [3:0] hop;
    logic [1:0] drive;
    logic       fin;
    logic [1:0] fin_code;

    fsm16_route_rom u_route (
        .cur (fsm_state),
        .tgt (tgt_reg),
        .hop (hop)
    );

    // State and output registers; reset returns everything to idle at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_reg       <= CTL_IDLE;
            tgt_reg       <= 4'd0;
            exp_reg       <= 4'd0;
            chk_en_reg    <= 1'b0;
            steps_reg     <= '0;
            done_reg      <= 1'b0;
            status_reg    <= ST_OK;
            steps_out_reg <= '0;
        end else begin
            ctl_reg       <= ctl_next;
            tgt_reg       <= tgt_next;
            exp_reg       <= exp_next;
            chk_en_reg    <= chk_en_next;
            steps_reg     <= steps_next;
            done_reg      <= done_next;
            status_reg    <= status_next;
            steps_out_reg <= steps_out_next;
        end
    end

    // Control: accept in idle; in run check, finish, or drive one hop per cycle
    always_comb begin
        ctl_next       = ctl_reg;
        tgt_next       = tgt_reg;
        exp_next       = exp_reg;
        chk_en_next    = chk_en_reg;
        steps_next     = steps_reg;
        done_next      = 1'b0;
        status_next    = status_reg;
        steps_out_next = steps_out_reg;
        drive          = 2'b00;
        fin            = 1'b0;
        fin_code       = ST_OK;
        case (ctl_reg)
            CTL_IDLE: begin
                if (req_valid) begin
                    tgt_next    = req_target;
                    steps_next  = '0;
                    chk_en_next = 1'b0;
                    ctl_next    = CTL_RUN;
                end
            end
            CTL_RUN: begin
                if (chk_en_reg && fsm_state != exp_reg) begin
                    fin      = 1'b1;
                    fin_code = ST_MISMATCH;
                end else if (fsm_state == tgt_reg) begin
                    fin      = 1'b1;
                    fin_code = ST_OK;
                end else if (steps_reg == STEP_W'(MAX_STEPS)) begin
                    fin      = 1'b1;
                    fin_code = ST_TIMEOUT;
                end else begin
                    drive       = enc(fsm_state, hop);
                    exp_next    = hop;
                    chk_en_next = 1'b1;
                    steps_next  = steps_reg + STEP_W'(1);
                end
                // Inputs stay 00 on the finishing cycle; done follows a cycle later
                if (fin) begin
                    done_next      = 1'b1;
                    status_next    = fin_code;
                    steps_out_next = steps_reg;
                    ctl_next       = CTL_IDLE;
                end
            end
            default: ctl_next = CTL_IDLE;
        endcase
    end

    assign req_ready   = (ctl_reg == CTL_IDLE);
    assign input1      = drive[1];
    assign input2      = drive[0];
    assign done        = done_reg;
    assign status      = status_reg;
    assign steps_taken = steps_out_reg;

endmodule

// File: tb/tb_fsm16_steer.sv
// Bench: two steering units (MAX_STEPS 8 and 2), each closed around its own
// golden fsm_16 model. Expected outcomes and drive pairs go into scoreboard
// queues when a request is issued and are popped as the DUT responds.
module tb_fsm16_steer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid  [2];
    logic       req_ready  [2];
    logic [3:0] req_target [2];
    logic       input1     [2];
    logic       input2     [2];
    logic       done       [2];
    logic [1:0] status     [2];
    logic [3:0] fsm_q      [2];
    logic [3:0] fsm_prev   [2];
    logic       hold       [2];
    logic       fault;
    logic [3:0] steps0;
    logic [1:0] steps1;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        int status;
        int steps;
        int fin;
    } exp_t;

    exp_t sb_q[$];
    int   drv_q[$];

    always #5 clk = ~clk;

    fsm16_steer #(.MAX_STEPS(8)) dut0 (
        .clk         (clk),
        .reset       (reset_n),
        .req_valid   (req_valid[0]),
        .req_ready   (req_ready[0]),
        .req_target  (req_target[0]),
        .fsm_state   (fsm_q[0]),
        .input1      (input1[0]),
        .input2      (input2[0]),
        .done        (done[0]),
        .status      (status[0]),
        .steps_taken (steps0)
    );

    fsm16_steer #(.MAX_STEPS(2)) dut1 (
        .clk         (clk),
        .reset       (reset_n),
        .req_valid   (req_valid[1]),
        .req_ready   (req_ready[1]),
        .req_target  (req_target[1]),
        .fsm_state   (fsm_q[1]),
        .input1      (input1[1]),
        .input2      (input2[1]),
        .done        (done[1]),
        .status      (status[1]),
        .steps_taken (steps1)
    );

    // Golden fsm_16 row evaluation; flt swaps the j2/j3 rows
    function automatic logic [3:0] model_next(input logic [3:0] s, input logic i1,
                                              input logic i2, input logic flt);
        logic [2:0] j;
        logic       c;
        j = s[2:0];
        if (flt && j == 3'd2) j = 3'd3;
        else if (flt && j == 3'd3) j = 3'd2;
        case (j)
            3'd0:    c = i1 & i2;
            3'd1:    c = !i1 & i2;
            3'd2:    c = i1 & !i2;
            3'd3:    c = !i1 & !i2;
            3'd4:    c = i1 | i2;
            3'd5:    c = !i1 | i2;
            3'd6:    c = i1 | !i2;
            default: c = !i1 | !i2;
        endcase
        return c ? {j, 1'b1} : ({j, 1'b0} + 4'd2);
    endfunction

    // FSM models move every clock; hold forces S0
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            fsm_prev[k] <= fsm_q[k];
            if (hold[k]) fsm_q[k] <= 4'd0;
            else         fsm_q[k] <= model_next(fsm_q[k], input1[k], input2[k], (k == 0) && fault);
        end
    end

    task automatic check(input string tag, input int got, input int want);
        n_vectors++;
        if (got != want) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One steering transaction from S0. drv holds up to five expected pairs,
    // first pair in [9:8]. rst_at >= 0 asserts reset in that RUN cycle instead.
    task automatic run_req(input int k, input logic [3:0] tgt, input int st, input int n,
                           input int fin, input int n_drv, input logic [9:0] drv,
                           input int rst_at);
        exp_t e;
        bit   got_done;
        int   steps_v;
        @(negedge clk);
        hold[k]       = 1'b1;
        req_valid[k]  = 1'b1;
        req_target[k] = tgt;
        e.status = st;
        e.steps  = n;
        e.fin    = fin;
        sb_q.push_back(e);
        for (int i = 0; i < n_drv; i++) drv_q.push_back(int'(drv[9-2*i -: 2]));
        check("ready_idle", int'(req_ready[k]), 1);
        @(posedge clk);
        #1;
        hold[k]      = 1'b0;
        req_valid[k] = 1'b0;
        got_done     = 1'b0;
        for (int cyc = 0; cyc < 24 && !got_done; cyc++) begin
            @(negedge clk);
            if (rst_at == cyc) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_input1", int'(input1[k]), 0);
                check("rst_input2", int'(input2[k]), 0);
                check("rst_done", int'(done[k]), 0);
                sb_q.delete();
                drv_q.delete();
                @(posedge clk);
                @(negedge clk);
                reset_n      = 1'b1;
                req_valid[k] = 1'b0;
                hold[k]      = 1'b1;
                check("rst_ready", int'(req_ready[k]), 1);
                for (int w = 0; w < 4; w++) begin
                    @(negedge clk);
                    check("rst_no_done", int'(done[k]), 0);
                end
                $display("txn dut%0d tgt=%0d reset at run cycle %0d", k, tgt, rst_at);
                return;
            end
            if (done[k]) begin
                got_done = 1'b1;
                e = sb_q.pop_front();
                steps_v = (k == 0) ? int'(steps0) : int'(steps1);
                check("status", int'(status[k]), e.status);
                check("steps", steps_v, e.steps);
                check("fin_state", int'(fsm_prev[k]), e.fin);
                check("drives_left", drv_q.size(), 0);
                $display("txn dut%0d tgt=%0d status=%0d steps=%0d fin=S%0d cycles=%0d",
                         k, tgt, status[k], steps_v, fsm_prev[k], cyc + 1);
            end else begin
                check("drive_avail", int'(drv_q.size() > 0), 1);
                if (drv_q.size() > 0) check("drive", int'({input1[k], input2[k]}), drv_q.pop_front());
                check("ready_busy", int'(req_ready[k]), 0);
                // A request during RUN must be ignored
                if (n >= 1 && cyc == 0) begin
                    req_valid[k]  = 1'b1;
                    req_target[k] = 4'hF;
                end else begin
                    req_valid[k] = 1'b0;
                end
            end
        end
        req_valid[k] = 1'b0;
        check("done_seen", int'(got_done), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        fault   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hold[k]       = 1'b1;
            req_valid[k]  = 1'b0;
            req_target[k] = 4'd0;
        end
        repeat (3) @(negedge clk);
        check("reset_ready", int'(req_ready[0]), 1);
        check("reset_done", int'(done[0]), 0);
        check("reset_status", int'(status[0]), 0);
        check("reset_steps", int'(steps0), 0);
        check("reset_input1", int'(input1[0]), 0);
        check("reset_input2", int'(input2[0]), 0);
        check("reset_ready1", int'(req_ready[1]), 1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // k, tgt, status, steps, final state, #drives, drives, reset cycle
        run_req(0, 4'd0,  0, 0, 0,  1, 10'b00_00_00_00_00, -1);
        run_req(0, 4'd2,  0, 1, 2,  2, 10'b00_00_00_00_00, -1);
        run_req(0, 4'd8,  0, 3, 8,  4, 10'b11_01_11_00_00, -1);
        run_req(0, 4'd15, 0, 4, 15, 5, 10'b11_01_00_00_00, -1);
        run_req(0, 4'd5,  0, 2, 5,  3, 10'b00_10_00_00_00, -1);
        fault = 1'b1;
        run_req(0, 4'd8,  2, 3, 6,  4, 10'b11_01_11_00_00, -1);
        fault = 1'b0;
        run_req(1, 4'd8,  1, 2, 3,  3, 10'b11_01_00_00_00, -1);
        run_req(0, 4'd8,  0, 3, 8,  4, 10'b11_01_11_00_00, 2);
        run_req(0, 4'd8,  0, 3, 8,  4, 10'b11_01_11_00_00, -1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
